// File: rtl/mac_pkg.sv
// Shared types and defaults for the systolic column drain stage.
package mac_pkg;

    localparam int DEF_PSUM_W = 24;
    localparam int DEF_ACC_W  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic                 err;
        logic [DEF_ACC_W-1:0] data;
    } result_t;

endpackage

// File: rtl/drain_fifo.sv
// Synchronous flop-array FIFO with a registered head that keeps the last
// popped entry visible while empty.
module drain_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         vld,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [W-1:0] head_q, head_d;
    logic         empty, do_pop, do_push;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign vld     = ~empty;
    assign head    = head_q;

    always_comb begin
        wr_d   = wr_q + (AW+1)'(do_push);
        rd_d   = rd_q + (AW+1)'(do_pop);
        mem_d  = mem_q;
        head_d = head_q;
        if (do_push) mem_d[wr_q[AW-1:0]] = push_data;
        // New head may be the entry written this very cycle (push into empty or
        // push+pop at depth one); otherwise it is already in the array.
        if (wr_d != rd_d) begin
            if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) head_d = push_data;
            else                                          head_d = mem_q[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/mac_col_drain.sv
// Column drain: sums K-tile psums per group, queues tagged results, tracks
// protocol/overflow/error status.
module mac_col_drain
    import mac_pkg::*;
#(
    parameter int PSUM_W = DEF_PSUM_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int DEPTH  = 8,
    parameter int ECNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [PSUM_W-1:0] in_psum,
    input  logic              in_err,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_vld,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_err,
    input  logic              clr,
    output logic              fifo_full,
    output logic              overflow,
    output logic              proto_err,
    output logic [ECNT_W-1:0] err_cnt
);

    drain_state_e      state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              acc_err_q, acc_err_d;
    logic              overflow_q, overflow_d;
    logic              proto_err_q, proto_err_d;
    logic [ECNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [ACC_W-1:0]  psum_z, acc_sat;
    logic [ACC_W:0]    acc_sum;
    logic              push, push_err, proto_set;
    logic [ACC_W-1:0]  push_data;
    logic              pop, ovf_set;
    logic [ACC_W:0]    head;

    assign psum_z  = ACC_W'(in_psum);
    assign acc_sum = {1'b0, acc_q} + {1'b0, psum_z};
    assign acc_sat = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (in_vld) begin
            if (in_first)               state_d = in_last ? IDLE : ACC;
            else if (state_q == ACC && in_last) state_d = IDLE;
        end
    end

    // A first in ACC abandons the open group and reloads, same as from IDLE.
    always_comb begin
        acc_d     = acc_q;
        acc_err_d = acc_err_q;
        push      = 1'b0;
        push_data = acc_sat;
        push_err  = acc_err_q | in_err;
        proto_set = 1'b0;
        if (in_vld) begin
            if (in_first) begin
                acc_d     = psum_z;
                acc_err_d = in_err;
                push      = in_last;
                push_data = psum_z;
                push_err  = in_err;
                proto_set = (state_q == ACC);
            end else if (state_q == ACC) begin
                acc_d     = acc_sat;
                acc_err_d = acc_err_q | in_err;
                push      = in_last;
            end else begin
                proto_set = 1'b1;
            end
        end
    end

    assign pop     = out_vld & out_ready;
    assign ovf_set = push & fifo_full & ~pop;

    always_comb begin
        overflow_d  = (clr ? 1'b0 : overflow_q)  | ovf_set;
        proto_err_d = (clr ? 1'b0 : proto_err_q) | proto_set;
        err_cnt_d   = clr ? '0 : err_cnt_q;
        if (push && push_err && err_cnt_d != '1) err_cnt_d = err_cnt_d + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            acc_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            acc_q       <= acc_d;
            acc_err_q   <= acc_err_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    drain_fifo #(.W(ACC_W+1), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({push_err, push_data}),
        .pop       (pop),
        .full      (fifo_full),
        .vld       (out_vld),
        .head      (head)
    );

    assign out_data  = head[ACC_W-1:0];
    assign out_err   = head[ACC_W];
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
